spi_cmd_receiver: RTL and testbench
===================================

Name: spi_cmd_receiver

Overview:
SPI slave front end that deserialises host frames into the command/data word pair consumed by the command decoder. It synchronises the asynchronous SPI pins into sys_clk, counts bits per chip-select window, and issues a one-cycle cmd_valid per complete frame. MISO returns the previously accepted frame so the host can read back the last command. The block sits between the chip pins and cmd_decoder.

Parameters:
CMD_WIDTH, 8, command field width; the first bits of the frame.
DATAWORD_WIDTH, 16, data field width; the remaining bits of the frame.
SYNC_STAGES, 2, flip-flop synchroniser depth on spi_sclk, spi_cs_n and spi_mosi (minimum 2).

Ports:
sys_clk  in  1  system clock; sole clock domain.
sys_rst  in  1  synchronous, active-high reset.
spi_sclk  in  1  SPI clock, asynchronous; mode 0 (CPOL=0, CPHA=0).
spi_cs_n  in  1  chip select, active low, asynchronous.
spi_mosi  in  1  serial data in, MSB first.
spi_miso  out  1  serial data out, MSB first.
cmd_word  out  CMD_WIDTH  command field of the last complete frame.
data_word  out  DATAWORD_WIDTH  data field of the last complete frame.
cmd_valid  out  1  one-cycle pulse when a complete frame is accepted.
frame_err  out  1  one-cycle pulse when a frame is truncated (cs_n rises early).
overrun  out  1  sticky flag: sclk edges arrived after a full frame within the same cs_n window; cleared only by reset.

Behaviour:
- FRAME_BITS = CMD_WIDTH + DATAWORD_WIDTH (24 by default). The bit counter is wide enough to hold FRAME_BITS.
- Synchronisation: all three SPI inputs pass through SYNC_STAGES flops. One additional flop on sclk and on cs_n provides edge detection.
  - sclk_rise / sclk_fall and cs_fall / cs_rise are single-cycle strobes derived from the synchronised signals.
  - Requirement: sys_clk is at least 4x spi_sclk.
- Reset (sys_rst=1 at a sys_clk edge):
  - cmd_word=0, data_word=0, cmd_valid=0, frame_err=0, overrun=0, spi_miso=0.
  - Bit counter=0, rx/tx shift registers=0, last-frame register=0, state=IDLE.
  - Synchroniser flops reset to the idle levels: cs_n=1, sclk=0, mosi=0.
  - Reset mid-frame discards the partial frame. No cmd_valid and no frame_err are issued for it.
- State machine:
  - IDLE: cs_n high; spi_miso=0. On cs_fall: counter=0, tx shift reg loaded with the last-frame register, go to SHIFT.
  - SHIFT:
    - On sclk_rise: rx shift reg shifts left, taking synchronised mosi into the LSB; counter increments.
    - On sclk_fall: tx shift reg shifts left; spi_miso always drives the tx MSB.
    - When the sclk_rise takes the counter to FRAME_BITS, on that same clock edge:
      - cmd_word takes the upper CMD_WIDTH bits of the assembled frame; data_word takes the lower DATAWORD_WIDTH bits.
      - The last-frame register takes the full frame.
      - cmd_valid=1 for exactly one cycle.
      - Go to DONE.
    - Latency: cmd_valid is visible on the cycle after the synchronised 24th rising edge is detected.
    - On cs_rise with 0 < counter < FRAME_BITS: frame_err=1 for one cycle, no cmd_valid, outputs unchanged, go to IDLE.
    - On cs_rise with counter=0: go to IDLE silently.
  - DONE:
    - Any sclk_rise sets overrun=1; the extra bits are ignored and do not shift into the rx register.
    - spi_miso=0.
    - On cs_rise: go to IDLE.
- Simultaneous events:
  - cs_rise wins over sclk_rise in the same cycle; that edge is not counted.
  - cs_fall in IDLE coinciding with sclk_rise: only the frame start is taken.
- cmd_word and data_word hold their values between frames. cmd_valid is never asserted on two consecutive cycles.

Test Plan:
1. After reset, one 24-bit frame 0x12_ABCD, MSB first, at sclk = sys_clk/8 -> exactly one cmd_valid pulse; cmd_word=0x12, data_word=0xABCD; frame_err=0, overrun=0.
2. Back-to-back frames 0x01_0100 then 0x22_3FFF with cs_n high 4 sclk periods between them -> two cmd_valid pulses; the final outputs are 0x22/0x3FFF; during frame 2 spi_miso shifts out 0x010100, sampled on sclk rising edges.
3. Frame with cs_n raised after 10 bits -> frame_err pulses once, no cmd_valid, and cmd_word/data_word keep their prior values. A following full frame of 0x80_0005 is accepted correctly.
4. A 26-bit burst 0xFF_FFFF followed by 2 extra bits -> cmd_valid once with cmd_word=0xFF, data_word=0xFFFF; overrun=1 and it stays set across later valid frames until sys_rst.
5. sys_rst asserted after 12 bits of a frame, then released with cs_n still low and clocking continuing -> no cmd_valid and no frame_err; all outputs are 0. The next complete frame after cs_n cycles high/low is decoded correctly.
6. cs_n rising on the same synchronised cycle as the 24th sclk rise -> treated as truncated: frame_err=1, cmd_valid=0.

Source files
------------

// File: rtl/spi_cmd_receiver.sv
// SPI mode-0 slave front end: synchronises the pins into sys_clk, assembles a
// command/data frame per chip-select window and replays the last frame on MISO.
//   state | meaning
//   IDLE  | cs_n high (or not yet armed after reset), miso held low
//   SHIFT | frame in progress, sampling mosi on sclk rise, shifting miso on fall
//   DONE  | full frame taken; further sclk rises only flag overrun
module spi_cmd_receiver #(
    parameter int CMD_WIDTH      = 8,
    parameter int DATAWORD_WIDTH = 16,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      spi_sclk,
    input  logic                      spi_cs_n,
    input  logic                      spi_mosi,
    output logic                      spi_miso,
    output logic [CMD_WIDTH-1:0]      cmd_word,
    output logic [DATAWORD_WIDTH-1:0] data_word,
    output logic                      cmd_valid,
    output logic                      frame_err,
    output logic                      overrun
);
    localparam int FRAME_BITS = CMD_WIDTH + DATAWORD_WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam int SETTLE_W   = $clog2(SYNC_STAGES + 2);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    logic [SYNC_STAGES-1:0]    r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic                      r_sclk_d, r_cs_d;
    logic [SETTLE_W-1:0]       r_settle;
    logic                      r_armed;
    state_t                    r_state;
    logic [CNT_W-1:0]          r_count;
    logic [FRAME_BITS-1:0]     r_rx, r_tx, r_last;
    logic                      r_miso, r_valid, r_ferr, r_overrun;
    logic [CMD_WIDTH-1:0]      r_cmd;
    logic [DATAWORD_WIDTH-1:0] r_data;

    logic                  w_sclk, w_cs, w_mosi;
    logic                  w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
    logic [FRAME_BITS-1:0] w_frame;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_cs_fall   = ~w_cs & r_cs_d;
    assign w_cs_rise   = w_cs & ~r_cs_d;
    assign w_frame     = {r_rx[FRAME_BITS-2:0], w_mosi};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_sclk_d    <= w_sclk;
            r_cs_d      <= w_cs;
        end
    end

    // The synchroniser resets to cs_n=1, so a window already open at reset
    // would look like a fresh cs fall. Only arm once the real pin is seen high.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_settle <= '0;
            r_armed  <= 1'b0;
        end else if (r_settle != SETTLE_W'(SYNC_STAGES + 1)) begin
            r_settle <= r_settle + 1'b1;
        end else if (w_cs && r_cs_d) begin
            r_armed <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_rx      <= '0;
            r_tx      <= '0;
            r_last    <= '0;
            r_miso    <= 1'b0;
            r_cmd     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_miso <= 1'b0;
                    if (w_cs_fall && r_armed) begin
                        r_count <= '0;
                        r_tx    <= r_last;
                        r_miso  <= r_last[FRAME_BITS-1];
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_cs_rise) begin
                        r_ferr  <= (r_count != '0);
                        r_miso  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_sclk_rise) begin
                        r_rx    <= w_frame;
                        r_count <= r_count + 1'b1;
                        if (r_count == CNT_W'(FRAME_BITS - 1)) begin
                            r_cmd   <= w_frame[FRAME_BITS-1:DATAWORD_WIDTH];
                            r_data  <= w_frame[DATAWORD_WIDTH-1:0];
                            r_last  <= w_frame;
                            r_valid <= 1'b1;
                            r_miso  <= 1'b0;
                            r_state <= DONE;
                        end
                    end else if (w_sclk_fall) begin
                        r_tx   <= {r_tx[FRAME_BITS-2:0], 1'b0};
                        r_miso <= r_tx[FRAME_BITS-2];
                    end
                end
                DONE: begin
                    r_miso <= 1'b0;
                    if (w_cs_rise) begin
                        r_state <= IDLE;
                    end else if (w_sclk_rise) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign spi_miso  = r_miso;
    assign cmd_word  = r_cmd;
    assign data_word = r_data;
    assign cmd_valid = r_valid;
    assign frame_err = r_ferr;
    assign overrun   = r_overrun;
endmodule

// File: tb/tb_spi_cmd_receiver.sv
// Directed bench for spi_cmd_receiver: frames driven at sclk = sys_clk/8,
// pulses counted by a monitor, outputs compared against hand-computed values.
module tb_spi_cmd_receiver;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [7:0]  cmd_word;
    logic [15:0] data_word;
    logic        cmd_valid, frame_err, overrun;

    int n_cmp = 0;
    int n_fail = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int n_consec = 0;
    logic prev_valid = 1'b0;

    spi_cmd_receiver dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .cmd_word(cmd_word), .data_word(data_word),
        .cmd_valid(cmd_valid), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (cmd_valid) n_valid++;
        if (frame_err) n_ferr++;
        if (cmd_valid && prev_valid) n_consec++;
        prev_valid = cmd_valid;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic shift_bits(input logic [31:0] pat, input int nbits, inout logic [31:0] rd);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_mosi = pat[i];
            cyc(4);
            rd = {rd[30:0], spi_miso};
            spi_sclk = 1'b1;
            cyc(4);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [31:0] pat, input int nbits, output logic [31:0] rd);
        rd = '0;
        spi_cs_n = 1'b0;
        cyc(8);
        shift_bits(pat, nbits, rd);
        cyc(4);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        cyc(32);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        cyc(4);
        sys_rst = 1'b0;
        cyc(10);
        n_cmp++; if (cmd_word !== 8'h00) begin n_fail++; $display("FAIL reset_cmd got %h want 00", cmd_word); end
        n_cmp++; if (data_word !== 16'h0000) begin n_fail++; $display("FAIL reset_data got %h want 0000", data_word); end
        n_cmp++; if ({cmd_valid, frame_err, overrun, spi_miso} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {cmd_valid, frame_err, overrun, spi_miso}); end
    endtask

    task automatic test_single_frame();
        logic [31:0] rd;
        int v0, e0;
        v0 = n_valid; e0 = n_ferr;
        frame(32'h0012ABCD, 24, rd);
        n_cmp++; if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL single_valid_count got %0d want 1", n_valid - v0); end
        n_cmp++; if (cmd_word !== 8'h12) begin n_fail++; $display("FAIL single_cmd got %h want 12", cmd_word); end
        n_cmp++; if (data_word !== 16'hABCD) begin n_fail++; $display("FAIL single_data got %h want abcd", data_word); end
        n_cmp++; if (n_ferr - e0 !== 0 || overrun !== 1'b0) begin n_fail++; $display("FAIL single_err got ferr=%0d ovr=%b want 0/0", n_ferr - e0, overrun); end
        n_cmp++; if (rd[23:0] !== 24'h000000) begin n_fail++; $display("FAIL single_readback got %h want 000000", rd[23:0]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd1, rd2;
        int v0;
        v0 = n_valid;
        frame(32'h00010100, 24, rd1);
        frame(32'h00223FFF, 24, rd2);
        n_cmp++; if (n_valid - v0 !== 2) begin n_fail++; $display("FAIL b2b_valid_count got %0d want 2", n_valid - v0); end
        n_cmp++; if ({cmd_word, data_word} !== 24'h223FFF) begin n_fail++; $display("FAIL b2b_words got %h want 223fff", {cmd_word, data_word}); end
        n_cmp++; if (rd1[23:0] !== 24'h12ABCD) begin n_fail++; $display("FAIL b2b_readback1 got %h want 12abcd", rd1[23:0]); end
        n_cmp++; if (rd2[23:0] !== 24'h010100) begin n_fail++; $display("FAIL b2b_readback2 got %h want 010100", rd2[23:0]); end
    endtask

    task automatic test_truncated();
        logic [31:0] rd;
        int v0, e0;
        v0 = n_valid; e0 = n_ferr;
        frame(32'h000003A5, 10, rd);
        n_cmp++; if (n_ferr - e0 !== 1) begin n_fail++; $display("FAIL trunc_ferr_count got %0d want 1", n_ferr - e0); end
        n_cmp++; if (n_valid - v0 !== 0) begin n_fail++; $display("FAIL trunc_valid_count got %0d want 0", n_valid - v0); end
        n_cmp++; if ({cmd_word, data_word} !== 24'h223FFF) begin n_fail++; $display("FAIL trunc_hold got %h want 223fff", {cmd_word, data_word}); end
        v0 = n_valid;
        frame(32'h00800005, 24, rd);
        n_cmp++; if (n_valid - v0 !== 1 || {cmd_word, data_word} !== 24'h800005) begin n_fail++; $display("FAIL trunc_next got cnt=%0d words=%h want 1/800005", n_valid - v0, {cmd_word, data_word}); end
    endtask

    task automatic test_cs_with_last_edge();
        logic [31:0] rd;
        int v0, e0;
        v0 = n_valid; e0 = n_ferr;
        rd = '0;
        spi_cs_n = 1'b0;
        cyc(8);
        shift_bits(32'h00C3C3C3, 23, rd);
        spi_mosi = 1'b1;
        cyc(4);
        spi_sclk = 1'b1;
        spi_cs_n = 1'b1;
        cyc(4);
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        cyc(32);
        n_cmp++; if (n_ferr - e0 !== 1) begin n_fail++; $display("FAIL coinc_ferr_count got %0d want 1", n_ferr - e0); end
        n_cmp++; if (n_valid - v0 !== 0) begin n_fail++; $display("FAIL coinc_valid_count got %0d want 0", n_valid - v0); end
        n_cmp++; if ({cmd_word, data_word} !== 24'h800005) begin n_fail++; $display("FAIL coinc_hold got %h want 800005", {cmd_word, data_word}); end
    endtask

    task automatic test_overrun();
        logic [31:0] rd;
        int v0;
        v0 = n_valid;
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_pre got %b want 0", overrun); end
        frame(32'h03FFFFFF, 26, rd);
        n_cmp++; if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL ovr_valid_count got %0d want 1", n_valid - v0); end
        n_cmp++; if ({cmd_word, data_word} !== 24'hFFFFFF) begin n_fail++; $display("FAIL ovr_words got %h want ffffff", {cmd_word, data_word}); end
        n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %b want 1", overrun); end
        n_cmp++; if (rd[25:0] !== {24'h800005, 2'b00}) begin n_fail++; $display("FAIL ovr_readback got %h want %h", rd[25:0], {24'h800005, 2'b00}); end
        frame(32'h00334455, 24, rd);
        n_cmp++; if (overrun !== 1'b1 || {cmd_word, data_word} !== 24'h334455) begin n_fail++; $display("FAIL ovr_sticky got ovr=%b words=%h want 1/334455", overrun, {cmd_word, data_word}); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rd;
        int v0, e0;
        v0 = n_valid; e0 = n_ferr;
        rd = '0;
        spi_cs_n = 1'b0;
        cyc(8);
        shift_bits(32'h00000ABC, 12, rd);
        sys_rst = 1'b1;
        cyc(3);
        sys_rst = 1'b0;
        shift_bits(32'h00000DEF, 12, rd);
        cyc(4);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        cyc(32);
        n_cmp++; if (n_valid - v0 !== 0 || n_ferr - e0 !== 0) begin n_fail++; $display("FAIL rstmid_pulses got valid=%0d ferr=%0d want 0/0", n_valid - v0, n_ferr - e0); end
        n_cmp++; if ({cmd_word, data_word, overrun, spi_miso} !== 26'h0) begin n_fail++; $display("FAIL rstmid_outputs got %h want 0", {cmd_word, data_word, overrun, spi_miso}); end
        v0 = n_valid;
        frame(32'h005A1234, 24, rd);
        n_cmp++; if (n_valid - v0 !== 1 || {cmd_word, data_word} !== 24'h5A1234) begin n_fail++; $display("FAIL rstmid_next got cnt=%0d words=%h want 1/5a1234", n_valid - v0, {cmd_word, data_word}); end
        n_cmp++; if (rd[23:0] !== 24'h000000) begin n_fail++; $display("FAIL rstmid_readback got %h want 000000", rd[23:0]); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_truncated();
        test_cs_with_last_edge();
        test_overrun();
        test_reset_mid_frame();
        n_cmp++; if (n_consec !== 0) begin n_fail++; $display("FAIL valid_consecutive got %0d want 0", n_consec); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
